// File: rtl/activation_pipe.sv
// Three-stage piecewise-linear activation unit (sigmoid, tanh, relu, passthrough)
// over LANES independent signed Q-format lanes sharing one global advance enable.
module activation_pipe #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int LANES      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'd0,
        MODE_TANH    = 2'd1,
        MODE_RELU    = 2'd2,
        MODE_PASS    = 2'd3
    } mode_e;

    localparam int XW = WIDTH + 2;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef logic signed [XW-1:0]    wide_t;

    // Two guard bits let every add or doubling be evaluated exactly before clamping.
    localparam wide_t MAX_W  = {3'b000, {(WIDTH-1){1'b1}}};
    localparam wide_t MIN_W  = {3'b111, {(WIDTH-1){1'b0}}};
    localparam wide_t ONE_W  = wide_t'(1)  <<< FRAC_WIDTH;
    localparam wide_t TWO_W  = wide_t'(2)  <<< FRAC_WIDTH;
    localparam wide_t FIVE_W = wide_t'(5)  <<< FRAC_WIDTH;
    localparam wide_t KNEE_W = wide_t'(19) <<< (FRAC_WIDTH - 3);
    localparam wide_t HALF_W = wide_t'(1)  <<< (FRAC_WIDTH - 1);
    localparam wide_t OFS1_W = wide_t'(5)  <<< (FRAC_WIDTH - 3);
    localparam wide_t OFS2_W = wide_t'(27) <<< (FRAC_WIDTH - 5);

    function automatic wide_t ext(input word_t v);
        return wide_t'(v);
    endfunction

    function automatic word_t sat(input wide_t v);
        if (v > MAX_W) return word_t'(MAX_W);
        if (v < MIN_W) return word_t'(MIN_W);
        return word_t'(v);
    endfunction

    // tanh is evaluated through sigmoid(2x), so the doubling happens up front.
    function automatic word_t scaleIn(input mode_e m, input word_t x);
        if (m == MODE_TANH) return sat(ext(x) <<< 1);
        return x;
    endfunction

    function automatic word_t absSat(input word_t y);
        return y[WIDTH-1] ? sat(-ext(y)) : y;
    endfunction

    function automatic word_t segment(input word_t a);
        wide_t aw;
        aw = ext(a);
        if (aw >= FIVE_W) return word_t'(ONE_W);
        if (aw >= KNEE_W) return sat((aw >>> 5) + OFS2_W);
        if (aw >= ONE_W)  return sat((aw >>> 3) + OFS1_W);
        return sat((aw >>> 2) + HALF_W);
    endfunction

    function automatic word_t finalise(input mode_e m, input word_t x, input logic neg,
                                       input logic hi, input logic lo, input word_t sp);
        word_t s;
        s = neg ? sat(ONE_W - ext(sp)) : sp;
        case (m)
            MODE_SIGMOID: return s;
            MODE_TANH: begin
                if (lo) return word_t'(-ONE_W);
                if (hi) return word_t'(ONE_W);
                return sat(ext(sat(ext(s) <<< 1)) - ONE_W);
            end
            MODE_RELU: return x[WIDTH-1] ? '0 : x;
            default:   return x;
        endcase
    endfunction

    logic  en;
    word_t laneIn   [LANES];
    word_t scaledIn [LANES];

    logic  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    mode_e mode1_q, mode1_d, mode2_q, mode2_d;

    word_t x1_q  [LANES];
    word_t x1_d  [LANES];
    word_t a1_q  [LANES];
    word_t a1_d  [LANES];
    logic  neg1_q[LANES];
    logic  neg1_d[LANES];
    logic  hi1_q [LANES];
    logic  hi1_d [LANES];
    logic  lo1_q [LANES];
    logic  lo1_d [LANES];

    word_t x2_q  [LANES];
    word_t x2_d  [LANES];
    word_t sp2_q [LANES];
    word_t sp2_d [LANES];
    logic  neg2_q[LANES];
    logic  neg2_d[LANES];
    logic  hi2_q [LANES];
    logic  hi2_d [LANES];
    logic  lo2_q [LANES];
    logic  lo2_d [LANES];

    word_t out_q [LANES];
    word_t out_d [LANES];

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign laneIn[g]                    = word_t'(in_data[g*WIDTH +: WIDTH]);
        assign scaledIn[g]                  = scaleIn(mode_e'(in_mode), laneIn[g]);
        assign out_data[g*WIDTH +: WIDTH]   = out_q[g];
    end

    // Each stage only reloads its data when a real beat moves into it, so
    // bubbles never disturb the values last presented downstream.
    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        mode1_d = mode1_q;
        mode2_d = mode2_q;
        x1_d    = x1_q;
        a1_d    = a1_q;
        neg1_d  = neg1_q;
        hi1_d   = hi1_q;
        lo1_d   = lo1_q;
        x2_d    = x2_q;
        sp2_d   = sp2_q;
        neg2_d  = neg2_q;
        hi2_d   = hi2_q;
        lo2_d   = lo2_q;
        out_d   = out_q;

        if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;

            if (in_valid) begin
                mode1_d = mode_e'(in_mode);
                for (int k = 0; k < LANES; k++) begin
                    x1_d[k]   = laneIn[k];
                    a1_d[k]   = absSat(scaledIn[k]);
                    neg1_d[k] = scaledIn[k][WIDTH-1];
                    hi1_d[k]  = (ext(laneIn[k]) >= TWO_W);
                    lo1_d[k]  = (ext(laneIn[k]) <= -TWO_W);
                end
            end

            if (v1_q) begin
                mode2_d = mode1_q;
                for (int k = 0; k < LANES; k++) begin
                    x2_d[k]   = x1_q[k];
                    sp2_d[k]  = segment(a1_q[k]);
                    neg2_d[k] = neg1_q[k];
                    hi2_d[k]  = hi1_q[k];
                    lo2_d[k]  = lo1_q[k];
                end
            end

            if (v2_q) begin
                for (int k = 0; k < LANES; k++) begin
                    out_d[k] = finalise(mode2_q, x2_q[k], neg2_q[k], hi2_q[k], lo2_q[k], sp2_q[k]);
                end
            end
        end
    end

    // Reset flushes every stage, so beats in flight at reset never reappear.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= MODE_SIGMOID;
            mode2_q <= MODE_SIGMOID;
            for (int k = 0; k < LANES; k++) begin
                x1_q[k]   <= '0;
                a1_q[k]   <= '0;
                neg1_q[k] <= 1'b0;
                hi1_q[k]  <= 1'b0;
                lo1_q[k]  <= 1'b0;
                x2_q[k]   <= '0;
                sp2_q[k]  <= '0;
                neg2_q[k] <= 1'b0;
                hi2_q[k]  <= 1'b0;
                lo2_q[k]  <= 1'b0;
                out_q[k]  <= '0;
            end
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            mode1_q <= mode1_d;
            mode2_q <= mode2_d;
            x1_q    <= x1_d;
            a1_q    <= a1_d;
            neg1_q  <= neg1_d;
            hi1_q   <= hi1_d;
            lo1_q   <= lo1_d;
            x2_q    <= x2_d;
            sp2_q   <= sp2_d;
            neg2_q  <= neg2_d;
            hi2_q   <= hi2_d;
            lo2_q   <= lo2_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Self-checking bench for activation_pipe: directed corner cases followed by
// randomized traffic, checked against an integer reference of the activation rules.
module tb_activation_pipe;

    localparam int W    = 17;
    localparam int L    = 4;
    localparam int DW   = W * L;
    localparam int QMAX = 65535;
    localparam int QMIN = -65536;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    activation_pipe #(
        .INT_WIDTH (8),
        .FRAC_WIDTH(8),
        .WIDTH     (W),
        .LANES     (L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    int            testsRun  = 0;
    int            failCount = 0;
    int            sentCount = 0;
    int            recvCount = 0;
    logic          slotValid [3];
    logic [DW-1:0] slotData  [3];
    int            edges [12] = '{-65536, 65535, 1280, 1279, 608, 607, 256, 255, 512, -512, -511, 0};

    // Reference arithmetic in Q8.8: 1.0 = 256, 5.0 = 1280, 2.375 = 608.
    function automatic int satv(input int v);
        if (v > QMAX) return QMAX;
        if (v < QMIN) return QMIN;
        return v;
    endfunction

    function automatic int sigPos(input int a);
        if (a >= 1280) return 256;
        if (a >= 608)  return satv(a / 32 + 216);
        if (a >= 256)  return satv(a / 8 + 160);
        return satv(a / 4 + 128);
    endfunction

    function automatic int sigmoidRef(input int x);
        if (x >= 0) return sigPos(x);
        return satv(256 - sigPos(satv(-x)));
    endfunction

    function automatic int tanhRef(input int x);
        if (x <= -512) return -256;
        if (x >= 512)  return 256;
        return satv(satv(2 * sigmoidRef(satv(2 * x))) - 256);
    endfunction

    function automatic logic [DW-1:0] modelBeat(input logic [1:0] m, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        int x;
        int y;
        r = '0;
        for (int k = 0; k < L; k++) begin
            x = int'($signed(d[k*W +: W]));
            case (m)
                2'd0:    y = sigmoidRef(x);
                2'd1:    y = tanhRef(x);
                2'd2:    y = (x < 0) ? 0 : x;
                default: y = x;
            endcase
            r[k*W +: W] = W'(y);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [DW-1:0] r;
        r[0*W +: W] = W'(a);
        r[1*W +: W] = W'(b);
        r[2*W +: W] = W'(c);
        r[3*W +: W] = W'(d);
        return r;
    endfunction

    function automatic int randLane();
        case ($urandom_range(0, 3))
            0, 1:    return int'($urandom_range(0, 3072)) - 1536;
            2:       return int'($urandom_range(0, 131071)) - 65536;
            default: return edges[$urandom_range(0, 11)];
        endcase
    endfunction

    function automatic logic [DW-1:0] randBeat();
        return pack4(randLane(), randLane(), randLane(), randLane());
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares the DUT against the three-slot model, then advances the model
    // exactly when the global enable allows it.
    task automatic checkCycle(input string tag);
        logic expEn;
        expEn = !slotValid[2] || out_ready;
        checkOutput({tag, ".in_ready"}, DW'(in_ready), DW'(expEn));
        checkOutput({tag, ".out_valid"}, DW'(out_valid), DW'(slotValid[2]));
        if (slotValid[2]) checkOutput({tag, ".out_data"}, out_data, slotData[2]);
        if (out_valid && out_ready) recvCount++;
        if (expEn) begin
            slotValid[2] = slotValid[1];
            slotData[2]  = slotData[1];
            slotValid[1] = slotValid[0];
            slotData[1]  = slotData[0];
            slotValid[0] = in_valid;
            slotData[0]  = in_valid ? modelBeat(in_mode, in_data) : '0;
            if (in_valid) sentCount++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [DW-1:0] d,
                                 input logic ordy, input string tag);
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = ordy;
        #1;
        checkCycle(tag);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput({tag, ".out_valid"}, DW'(out_valid), '0);
        checkOutput({tag, ".out_data"}, out_data, '0);
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput({tag, ".in_ready"}, DW'(in_ready), DW'(1'b1));
        for (int i = 0; i < 3; i++) begin
            slotValid[i] = 1'b0;
            slotData[i]  = '0;
        end
        sentCount = 0;
        recvCount = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slotValid[i] = 1'b0;
            slotData[i]  = '0;
        end
        repeat (2) @(negedge clk);
        doReset("por");

        applyStimulus(1'b1, 2'd0, pack4(0, 256, -256, 1280), 1'b1, "sig.in");
        repeat (2) applyStimulus(1'b0, 2'd0, '0, 1'b1, "sig.wait");
        applyStimulus(1'b0, 2'd0, '0, 1'b1, "sig.out");
        checkOutput("sig.vector", out_data, pack4(128, 192, 64, 256));

        applyStimulus(1'b1, 2'd1, pack4(0, 256, 768, -768), 1'b1, "tanh.in");
        repeat (2) applyStimulus(1'b0, 2'd0, '0, 1'b1, "tanh.wait");
        applyStimulus(1'b0, 2'd0, '0, 1'b1, "tanh.out");
        checkOutput("tanh.vector", out_data, pack4(0, 192, 256, -256));

        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, (i % 2 == 0) ? 2'd2 : 2'd3, pack4(-1280, -1280, -1280, -1280), 1'b1, "alt");
        repeat (4) applyStimulus(1'b0, 2'd0, '0, 1'b1, "alt.drain");

        applyStimulus(1'b1, 2'd0, pack4(300, -700, 1500, 10), 1'b1, "stall.a");
        applyStimulus(1'b1, 2'd1, pack4(-300, 100, 511, -511), 1'b1, "stall.b");
        applyStimulus(1'b1, 2'd3, pack4(7, -7, 65535, -65536), 1'b1, "stall.c");
        repeat (5) applyStimulus(1'b1, 2'd2, pack4(-5, 5, -65536, 65535), 1'b0, "stall.hold");
        applyStimulus(1'b1, 2'd2, pack4(-5, 5, -65536, 65535), 1'b1, "stall.release");
        repeat (4) applyStimulus(1'b0, 2'd0, '0, 1'b1, "stall.drain");
        checkOutput("stall.count", DW'(recvCount), DW'(sentCount));

        applyStimulus(1'b1, 2'd0, pack4(1, 2, 3, 4), 1'b1, "flush.a");
        applyStimulus(1'b1, 2'd1, pack4(5, 6, 7, 8), 1'b1, "flush.b");
        applyStimulus(1'b1, 2'd3, pack4(9, 10, 11, 12), 1'b1, "flush.c");
        doReset("flush");
        repeat (4) applyStimulus(1'b0, 2'd0, '0, 1'b1, "flush.idle");

        applyStimulus(1'b1, 2'd0, pack4(QMIN, QMIN, QMIN, QMIN), 1'b1, "minneg.sig");
        applyStimulus(1'b1, 2'd1, pack4(QMIN, QMIN, QMIN, QMIN), 1'b1, "minneg.tanh");
        repeat (2) applyStimulus(1'b0, 2'd0, '0, 1'b1, "minneg.wait");
        checkOutput("minneg.sig.vector", out_data, pack4(0, 0, 0, 0));
        applyStimulus(1'b0, 2'd0, '0, 1'b1, "minneg.out");
        checkOutput("minneg.tanh.vector", out_data, pack4(-256, -256, -256, -256));

        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), randBeat(),
                          $urandom_range(0, 9) < 7, "rand");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 2'd0, '0, 1'b1, "rand.drain");
        checkOutput("rand.count", DW'(recvCount), DW'(sentCount));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
